// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz step-count blocks (forward counter and inverse search).
package collatz_pkg;

   localparam int VAL_W_DEF = 16;
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_CHECK,
      ST_DONE
   } state_e;

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: v/2 for even v, 3v+1 for odd v, with overflow detection on 3v+1.
module collatz_step
   import collatz_pkg::*;
#(
   parameter int VAL_W = VAL_W_DEF
) (
   input  logic [VAL_W-1:0] v,
   output logic [VAL_W-1:0] next_v,
   output logic             ovf_out
);

   // Two extra bits hold the full 3v+1 result so overflow is just the top bits.
   logic [VAL_W+1:0] tri_p1;

   assign tri_p1  = {2'b00, v} + {1'b0, v, 1'b0} + (VAL_W+2)'(1);
   assign next_v  = v[0] ? tri_p1[VAL_W-1:0] : {1'b0, v[VAL_W-1:1]};
   assign ovf_out = v[0] & (|tri_p1[VAL_W+1:VAL_W]);

endmodule

// File: rtl/collatz_inverse_search.sv
// Finds the smallest N in [1, N_MAX] whose Collatz trajectory reaches 1 in exactly `target` steps.
module collatz_inverse_search
   import collatz_pkg::*;
#(
   parameter int N_MAX = 255,
   parameter int VAL_W = VAL_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] target,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [7:0]       n_out,
   output logic             ovf
);

   localparam int unsigned VAL_MAX = (32'd1 << VAL_W) - 32'd1;

   state_e           state_q;
   logic [7:0]       cand_q;
   logic [VAL_W-1:0] val_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] tgt_q;
   logic             cand_ovf_q;
   logic             busy_q;
   logic             done_q;
   logic             found_q;
   logic [7:0]       n_q;
   logic             ovf_q;

   logic [VAL_W-1:0] step_v;
   logic             step_ovf;
   logic             cand_fits;

   collatz_step #(.VAL_W(VAL_W)) u_step (
      .v       (val_q),
      .next_v  (step_v),
      .ovf_out (step_ovf)
   );

   // A candidate wider than the value register can never be evaluated faithfully.
   assign cand_fits = (32'(cand_q) <= VAL_MAX);

   // NOTE: every register here, including the datapath, is reset so an aborted
   // search leaves no stale state; all state updates use non-blocking assignment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cand_q     <= '0;
         val_q      <= '0;
         cnt_q      <= '0;
         tgt_q      <= '0;
         cand_ovf_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         n_q        <= '0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tgt_q   <= target;
                  cand_q  <= 8'd1;
                  found_q <= 1'b0;
                  n_q     <= '0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               val_q      <= VAL_W'(cand_q);
               cnt_q      <= '0;
               cand_ovf_q <= !cand_fits;
               if (!cand_fits) ovf_q <= 1'b1;
               state_q    <= ST_ITER;
            end
            ST_ITER: begin
               if (cand_ovf_q || val_q == VAL_W'(1) || cnt_q == tgt_q) begin
                  state_q <= ST_CHECK;
               end else if (step_ovf) begin
                  ovf_q      <= 1'b1;
                  cand_ovf_q <= 1'b1;
                  state_q    <= ST_CHECK;
               end else begin
                  val_q <= step_v;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               if (!cand_ovf_q && val_q == VAL_W'(1) && cnt_q == tgt_q) begin
                  found_q <= 1'b1;
                  n_q     <= cand_q;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (cand_q == 8'(N_MAX)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cand_q  <= cand_q + 8'd1;
                  state_q <= ST_LOAD;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign found = found_q;
   assign n_out = n_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_collatz_inverse_search.sv
// Randomized and directed bench for collatz_inverse_search against an arithmetic search model.
module tb_collatz_inverse_search;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] target_a = '0, target_b = '0;
   logic       busy_a, done_a, found_a, ovf_a;
   logic       busy_b, done_b, found_b, ovf_b;
   logic [7:0] n_a, n_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   collatz_inverse_search dut (
      .clk(clk), .rst_n(rst_n), .start(start_a), .target(target_a),
      .busy(busy_a), .done(done_a), .found(found_a), .n_out(n_a), .ovf(ovf_a)
   );

   collatz_inverse_search #(.VAL_W(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .target(target_b),
      .busy(busy_b), .done(done_b), .found(found_b), .n_out(n_b), .ovf(ovf_b)
   );

   task automatic check(input string tag, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: scan N upward, walking each trajectory with plain integer arithmetic.
   function automatic void model(input int tgt, input int valw, output bit fnd,
                                 output int n, output bit ov, output int cost);
      longint maxv;
      maxv = (longint'(1) << valw) - 1;
      fnd = 0; n = 0; ov = 0; cost = 0;
      for (int c = 1; c <= 255; c++) begin
         longint v;
         int k;
         bit bad;
         v = c; k = 0; bad = (c > maxv);
         if (!bad) begin
            while (v != 1 && k != tgt) begin
               if (v % 2 == 1) begin
                  if (3 * v + 1 > maxv) begin bad = 1; break; end
                  v = 3 * v + 1;
               end else begin
                  v = v / 2;
               end
               k++;
            end
         end
         ov = ov | bad;
         cost += 3 + k;
         if (!bad && v == 1 && k == tgt) begin fnd = 1; n = c; break; end
      end
   endfunction

   task automatic drive(input bit which, input bit s, input logic [7:0] t);
      if (which) begin start_b = s; target_b = t; end
      else       begin start_a = s; target_a = t; end
   endtask

   // Runs one search; restart_at>0 re-pulses start (target 3) mid-search, poke_done pulses start on the done cycle.
   task automatic run_search(input bit which, input int tgt, input int lit_n,
                             input int restart_at, input bit poke_done);
      bit efound, eovf;
      int en, ecost, cyc, busy_low;
      bit seen;
      string nm;
      nm = $sformatf("%s_t%0d", which ? "v5" : "v16", tgt);
      model(tgt, which ? 5 : 16, efound, en, eovf, ecost);
      @(negedge clk);
      drive(which, 1'b1, 8'(tgt));
      cyc = 0; busy_low = 0; seen = 0;
      while (cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) drive(which, 1'b0, 8'(tgt));
         if (restart_at > 0 && cyc == restart_at)     drive(which, 1'b1, 8'd3);
         if (restart_at > 0 && cyc == restart_at + 1) drive(which, 1'b0, 8'd3);
         if (which ? done_b : done_a) begin seen = 1; break; end
         if (!(which ? busy_b : busy_a)) busy_low++;
      end
      check({nm, "_done_seen"}, int'(seen), 1);
      if (!seen) return;
      check({nm, "_latency"}, cyc, ecost + 1);
      check({nm, "_busy_during"}, busy_low, 0);
      check({nm, "_busy_at_done"}, int'(which ? busy_b : busy_a), 0);
      check({nm, "_found"}, int'(which ? found_b : found_a), int'(efound));
      check({nm, "_n"}, int'(which ? n_b : n_a), en);
      check({nm, "_ovf"}, int'(which ? ovf_b : ovf_a), int'(eovf));
      if (lit_n >= 0) check({nm, "_n_known"}, int'(which ? n_b : n_a), lit_n);
      if (poke_done) drive(which, 1'b1, 8'd1);
      @(negedge clk);
      if (poke_done) drive(which, 1'b0, 8'd1);
      check({nm, "_done_pulse"}, int'(which ? done_b : done_a), 0);
      check({nm, "_n_hold"}, int'(which ? n_b : n_a), en);
      if (poke_done) begin
         @(negedge clk);
         check({nm, "_start_in_done_ignored"}, int'(which ? busy_b : busy_a), 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_found", int'(found_a), 0);
      check("rst_n_out", int'(n_a), 0);
      check("rst_ovf", int'(ovf_a), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_search(0, 0, 1, 0, 1'b1);
      run_search(0, 7, 3, 0, 1'b0);
      run_search(0, 111, 27, 0, 1'b0);
      run_search(0, 5, 5, 0, 1'b0);
      run_search(0, 1, 2, 0, 1'b0);
      run_search(0, 200, 0, 0, 1'b0);
      run_search(0, 111, 27, 10, 1'b0);

      // Random targets drawn from real trajectories so every search terminates early.
      for (int i = 0; i < 6; i++) begin
         int n0, t;
         longint v;
         n0 = $urandom_range(1, 60);
         v = n0; t = 0;
         while (v != 1) begin
            v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
            t++;
         end
         run_search(0, t, -1, 0, 1'b0);
      end

      // Abort a long search with an asynchronous reset between clock edges.
      @(negedge clk);
      drive(0, 1'b1, 8'd200);
      @(negedge clk);
      drive(0, 1'b0, 8'd200);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy_a), 0);
      check("abort_found", int'(found_a), 0);
      check("abort_n_out", int'(n_a), 0);
      check("abort_ovf", int'(ovf_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int done_cnt;
         done_cnt = 0;
         repeat (40) begin
            @(negedge clk);
            if (done_a) done_cnt++;
         end
         check("abort_no_done", done_cnt, 0);
      end
      run_search(0, 8, 6, 0, 1'b0);

      // Narrow value register: N=7 overflows, result must be the first in-range match.
      run_search(1, 10, 24, 0, 1'b0);
      run_search(1, 5, 5, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
